// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with same-cycle write bypass and a per-register busy
// scoreboard used by decode to stall on operands whose producer has not yet written back.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       any_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic              wr_ok;
    logic              iss_ok;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // The issue update comes last so that on a same-address collision the busy bit ends set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr] <= wr_data;
                busy_q[wr_addr] <= 1'b0;
            end
            if (iss_ok) begin
                busy_q[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] addr;
            addr = rd_addr[k*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if ((BYPASS != 0) && rst_n && wr_en && (wr_addr == addr)) begin
                // Forwarding is suppressed in reset so outputs stay cleared while rst_n is low.
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = 1'b0;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[addr];
                rd_busy[k]                  = busy_q[addr];
            end
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default, no-zero/no-bypass and 4-port/64-bit instances.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Default instance
    logic [9:0]  d_rd_addr;
    logic [63:0] d_rd_data;
    logic [1:0]  d_rd_busy;
    logic        d_wr_en, d_iss_en, d_any_busy;
    logic [4:0]  d_wr_addr, d_iss_addr;
    logic [31:0] d_wr_data;

    regfile_scoreboard u_def (
        .clk(clk), .rst_n(rst_n), .rd_addr(d_rd_addr), .rd_data(d_rd_data),
        .rd_busy(d_rd_busy), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
        .iss_en(d_iss_en), .iss_addr(d_iss_addr), .any_busy(d_any_busy)
    );

    // ZERO_REG=0, BYPASS=0 instance
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en, a_iss_en, a_any_busy;
    logic [4:0]  a_wr_addr, a_iss_addr;
    logic [31:0] a_wr_data;

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr), .any_busy(a_any_busy)
    );

    // NUM_RD=4, DATA_W=64, ADDR_W=4 instance
    logic [15:0]  w_rd_addr;
    logic [255:0] w_rd_data;
    logic [3:0]   w_rd_busy;
    logic         w_wr_en, w_iss_en, w_any_busy;
    logic [3:0]   w_wr_addr, w_iss_addr;
    logic [63:0]  w_wr_data;

    regfile_scoreboard #(.NUM_RD(4), .DATA_W(64), .ADDR_W(4)) u_wide (
        .clk(clk), .rst_n(rst_n), .rd_addr(w_rd_addr), .rd_data(w_rd_data),
        .rd_busy(w_rd_busy), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .iss_en(w_iss_en), .iss_addr(w_iss_addr), .any_busy(w_any_busy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        ab;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    vec_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic ie, input logic [4:0] ia,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic b0, input logic b1, input logic ab);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.ab = ab;
        return v;
    endfunction

    initial begin
        vec_t e;
        d_rd_addr = '0; d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0;
        d_iss_en = 1'b0; d_iss_addr = '0;
        a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_addr = '0;
        w_rd_addr = '0; w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
        w_iss_en = 1'b0; w_iss_addr = '0;

        // Expected values are what the read ports show before the edge of that row.
        vecs[0]  = mk(1'b1, 5'd3,  32'h11,       1'b0, 5'd0,  5'd3,  5'd0,
                      32'h11,       32'h0,        1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 5'd3,  32'h22,       1'b0, 5'd0,  5'd3,  5'd3,
                      32'h22,       32'h22,       1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd3,  5'd7,
                      32'h22,       32'h0,        1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,
                      32'h0,        32'h0,        1'b1, 1'b1, 1'b1);
        vecs[4]  = mk(1'b1, 5'd7,  32'h5A,       1'b0, 5'd0,  5'd7,  5'd3,
                      32'h5A,       32'h22,       1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,
                      32'h5A,       32'h0,        1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,
                      32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd7,
                      32'h0,        32'h5A,       1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,
                      32'h0,        32'h0,        1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 5'd9,  32'h77,       1'b1, 5'd9,  5'd9,  5'd1,
                      32'h77,       32'h0,        1'b0, 1'b0, 1'b1);
        vecs[10] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,
                      32'h77,       32'h77,       1'b1, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,
                      32'h77,       32'h77,       1'b1, 1'b1, 1'b1);
        vecs[12] = mk(1'b1, 5'd9,  32'h01,       1'b0, 5'd0,  5'd9,  5'd9,
                      32'h01,       32'h01,       1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b1, 5'd4,  32'h44,       1'b1, 5'd12, 5'd9,  5'd4,
                      32'h01,       32'h44,       1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd4,  5'd12,
                      32'h44,       32'h0,        1'b0, 1'b1, 1'b1);
        vecs[15] = mk(1'b1, 5'd12, 32'hABCD,     1'b1, 5'd4,  5'd12, 5'd4,
                      32'hABCD,     32'h44,       1'b0, 1'b0, 1'b1);
        vecs[16] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd12, 5'd4,
                      32'hABCD,     32'h44,       1'b0, 1'b1, 1'b1);

        // Reset state with a live bypass request: outputs must stay cleared.
        d_wr_en = 1'b1; d_wr_addr = 5'd5; d_wr_data = 32'hDEADBEEF;
        d_rd_addr = {5'd5, 5'd5};
        #2;
        chk("reset_rd_data", d_rd_data, 64'h0);
        chk("reset_rd_busy", {62'h0, d_rd_busy}, 64'h0);
        chk("reset_any_busy", {63'h0, d_any_busy}, 64'h0);
        d_wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven main sequence through the scoreboard queue.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            d_wr_en = vecs[i].we; d_wr_addr = vecs[i].wa; d_wr_data = vecs[i].wd;
            d_iss_en = vecs[i].ie; d_iss_addr = vecs[i].ia;
            d_rd_addr = {vecs[i].ra1, vecs[i].ra0};
            sb.push_back(vecs[i]);
            #2;
            e = sb.pop_front();
            chk($sformatf("vec%0d_d0", i), {32'h0, d_rd_data[31:0]}, {32'h0, e.d0});
            chk($sformatf("vec%0d_d1", i), {32'h0, d_rd_data[63:32]}, {32'h0, e.d1});
            chk($sformatf("vec%0d_busy", i), {62'h0, d_rd_busy}, {62'h0, e.b1, e.b0});
            chk($sformatf("vec%0d_any", i), {63'h0, d_any_busy}, {63'h0, e.ab});
        end

        // Asynchronous reset mid-operation.
        @(negedge clk);
        d_wr_en = 1'b1; d_wr_addr = 5'd5; d_wr_data = 32'hDEADBEEF; d_iss_en = 1'b0;
        d_rd_addr = {5'd4, 5'd5};
        @(negedge clk);
        d_wr_en = 1'b0;
        #2;
        chk("pre_rst_r5", {32'h0, d_rd_data[31:0]}, 64'hDEADBEEF);
        chk("pre_rst_any", {63'h0, d_any_busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_r5", {32'h0, d_rd_data[31:0]}, 64'h0);
        chk("async_rst_busy", {62'h0, d_rd_busy}, 64'h0);
        chk("async_rst_any", {63'h0, d_any_busy}, 64'h0);
        d_wr_en = 1'b1; d_wr_data = 32'h1234; d_iss_en = 1'b1; d_iss_addr = 5'd5;
        #1;
        chk("in_rst_bypass", {32'h0, d_rd_data[31:0]}, 64'h0);
        @(negedge clk);
        d_wr_en = 1'b0; d_iss_en = 1'b0;
        rst_n = 1'b1;
        #2;
        chk("post_rst_r5", {32'h0, d_rd_data[31:0]}, 64'h0);
        chk("post_rst_any", {63'h0, d_any_busy}, 64'h0);

        // ZERO_REG=0: r0 is an ordinary register; collision leaves it busy.
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_iss_en = 1'b1; a_iss_addr = 5'd0; a_rd_addr = {5'd3, 5'd0};
        @(negedge clk);
        a_wr_en = 1'b0; a_iss_en = 1'b0;
        #2;
        chk("alt_r0_data", {32'h0, a_rd_data[31:0]}, 64'hFFFFFFFF);
        chk("alt_r0_busy", {63'h0, a_rd_busy[0]}, 64'h1);
        chk("alt_any", {63'h0, a_any_busy}, 64'h1);

        // BYPASS=0: old value before the edge, new value after.
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h11;
        @(negedge clk);
        a_wr_data = 32'h22;
        #2;
        chk("alt_nobyp_pre", {32'h0, a_rd_data[63:32]}, 64'h11);
        @(negedge clk);
        a_wr_en = 1'b0;
        #2;
        chk("alt_nobyp_post", {32'h0, a_rd_data[63:32]}, 64'h22);

        // BYPASS=0: a pending write-back does not hide the stored busy bit.
        a_iss_en = 1'b1; a_iss_addr = 5'd7;
        @(negedge clk);
        a_iss_en = 1'b0;
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h5A; a_rd_addr = {5'd7, 5'd0};
        #2;
        chk("alt_busy_pre", {63'h0, a_rd_busy[1]}, 64'h1);
        chk("alt_data_pre", {32'h0, a_rd_data[63:32]}, 64'h0);
        @(negedge clk);
        a_wr_en = 1'b0;
        #2;
        chk("alt_busy_post", {63'h0, a_rd_busy[1]}, 64'h0);
        chk("alt_data_post", {32'h0, a_rd_data[63:32]}, 64'h5A);

        // Four ports, 64-bit data.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            w_wr_en = 1'b1;
            w_wr_addr = (i == 0) ? 4'd1 : (i == 1) ? 4'd2 : 4'd15;
            w_wr_data = (i == 0) ? 64'h1111_2222_3333_4444 :
                        (i == 1) ? 64'hA5A5_0000_FFFF_5A5A : 64'hF00D_CAFE_0123_4567;
        end
        @(negedge clk);
        w_wr_en = 1'b0;
        w_rd_addr = {4'd15, 4'd1, 4'd2, 4'd1};
        #2;
        chk("wide_p0", w_rd_data[63:0], 64'h1111_2222_3333_4444);
        chk("wide_p1", w_rd_data[127:64], 64'hA5A5_0000_FFFF_5A5A);
        chk("wide_p2", w_rd_data[191:128], 64'h1111_2222_3333_4444);
        chk("wide_p3", w_rd_data[255:192], 64'hF00D_CAFE_0123_4567);
        chk("wide_busy", {60'h0, w_rd_busy}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
